irq_arbiter: RTL
================

// Module: irq_arbiter
// PURPOSE
//  Interrupt controller in front of proc. Latches edge-triggered requests from N sources
//  (src 0 = key, src 1 = ethernet) together with a per-source 32-bit data word.
//  Arbitrates round-robin among the unmasked pending sources and presents one interrupt
//  at a time to proc on irq/irq_id/irq_data (irq_data drives proc interrupt_source_data).
//  Handshake: proc acknowledges trap entry with irq_ack and ISR exit with irq_done.
//  No nesting.
// PARAMETERS
//  NUM_SRC   2        number of interrupt sources (>=2)
//  DATA_W    32       width of per-source data word
//  MASK_RST  2'b11    reset value of enable mask (NUM_SRC bits, 1 = enabled)
// PORTS
//  clk          in   1                    system clock, rising edge
//  rst_n        in   1                    asynchronous active-low reset
//  src_req      in   NUM_SRC              per-source request, rising-edge detected
//  src_data     in   NUM_SRC*DATA_W       per-source data; slice i = [i*DATA_W +: DATA_W]
//  mask_we      in   1                    write enable mask
//  mask_wdata   in   NUM_SRC              new mask value
//  irq          out  1                    interrupt request to proc
//  irq_id       out  $clog2(NUM_SRC)      granted source index
//  irq_data     out  DATA_W               latched data of granted source
//  irq_ack      in   1                    proc has taken the trap (1-cycle pulse)
//  irq_done     in   1                    proc left the ISR (1-cycle pulse)
//  pending      out  NUM_SRC              pending flags
//  overflow     out  NUM_SRC              sticky: request lost while already pending
//  ovf_clr      in   1                    clears all overflow bits
// BEHAVIOUR
//  Reset:
//   - irq=0, irq_id=0, irq_data=0, pending=0, overflow=0, mask=MASK_RST, state=IDLE.
//   - src_req_q=0, last_grant=NUM_SRC-1, so src 0 wins first.
//  Edge detect: rise[i] = src_req[i] & ~src_req_q[i]; src_req_q is registered every cycle.
//  Pending and overflow on a rise:
//   - rise[i] with pending[i]=0: pending[i]<=1, data_q[i]<=src_data slice i.
//   - rise[i] with pending[i]=1: overflow[i]<=1; data_q[i] keeps the first word.
//   - Masked sources still latch pending and data. The mask only gates arbitration.
//  mask_we: the mask register updates at the same edge. Arbitration uses the registered mask.
//  FSM:
//   - IDLE:
//     - When (pending & mask) != 0, pick the first set bit scanning from last_grant+1
//       (wrapping).
//     - Register irq<=1, irq_id<=winner, irq_data<=data_q[winner]; go to ASSERT.
//     - Latency: rise sampled at edge N -> pending=1 after N -> irq=1 after edge N+1.
//   - ASSERT:
//     - irq, irq_id and irq_data are held stable.
//     - Masking the granted source does not retract irq.
//     - On irq_ack: pending[irq_id]<=0, last_grant<=irq_id, irq<=0; go to SERVICE.
//   - SERVICE:
//     - irq=0 and irq_data holds its value.
//     - On irq_done go to IDLE. Arbitration resumes on the next edge.
//   - irq_ack outside ASSERT and irq_done outside SERVICE are ignored.
//  Simultaneous events:
//   - rise[i] in the same cycle as the ack clearing pending[i]:
//     pending[i] stays 1, data_q[i] is updated, overflow is not set.
//   - ovf_clr in the same cycle as a new overflow: the set wins.
//   - irq_ack and irq_done in the same cycle while in ASSERT: only ack is taken.
//  Reset mid-operation: all state returns to reset values immediately (asynchronous).
//   In-flight and pending interrupts are discarded.
// TESTING
//  T1 Pulse src_req[0] at edge N with src_data[0]=32'hDEADBEEF.
//     -> irq=1 after N+1, irq_id=0, irq_data=DEADBEEF.
//     -> After the ack edge: irq=0, pending[0]=0.
//     -> irq_done returns to IDLE with irq staying 0.
//  T2 Rise src0 (32'h11111111) and src1 (32'h22222222) in the same cycle after reset.
//     -> Grant id 0 first. After ack+done, id 1 with 22222222 on the following edge.
//     -> Then both again -> id 0 (round-robin after 1).
//  T3 Two rises on src1 (32'hAAAA0001, then 32'hBBBB0002) with src1 masked.
//     -> overflow[1]=1. After unmask, irq_data=AAAA0001.
//     -> ovf_clr -> overflow=0.
//  T4 mask_wdata=2'b10, then rise src0.
//     -> pending[0]=1, irq stays 0 for 20 cycles.
//     -> Write mask 2'b11 -> irq=1 two edges after the mask_we edge.
//  T5 In ASSERT for src0, pulse src_req[0] in the same cycle as irq_ack.
//     -> pending[0]=1, overflow[0]=0, src0 re-granted with new data after irq_done.
//  T6 Drop rst_n mid-ASSERT with src1 pending.
//     -> irq=0, pending=0, overflow=0 immediately.
//     -> After release, no irq without a new rise.

Source files
------------

// File: rtl/irq_arbiter.sv
// Round-robin interrupt arbiter: latches edge-triggered requests and their data words,
// then presents one unmasked pending source at a time to the processor.
//
// state   | meaning
// IDLE    | no interrupt in flight; grant the next unmasked pending source
// ASSERT  | irq held high with stable id/data until the processor acknowledges
// SERVICE | processor is in its ISR; wait for irq_done
module irq_arbiter #(
  parameter int                 NUM_SRC  = 2,
  parameter int                 DATA_W   = 32,
  parameter logic [NUM_SRC-1:0] MASK_RST = 2'b11
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC-1:0]          src_req,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic                        mask_we,
  input  logic [NUM_SRC-1:0]          mask_wdata,
  output logic                        irq,
  output logic [$clog2(NUM_SRC)-1:0]  irq_id,
  output logic [DATA_W-1:0]           irq_data,
  input  logic                        irq_ack,
  input  logic                        irq_done,
  output logic [NUM_SRC-1:0]          pending,
  output logic [NUM_SRC-1:0]          overflow,
  input  logic                        ovf_clr
);

  localparam int ID_W = $clog2(NUM_SRC);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ASSERT  = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  logic [1:0]         state;
  logic [NUM_SRC-1:0] src_req_q;
  logic [NUM_SRC-1:0] mask;
  logic [ID_W-1:0]    last_grant;
  logic [DATA_W-1:0]  data_q [NUM_SRC];

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] req;
  logic [NUM_SRC-1:0] ack_clr;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    scan_idx;
  logic               found;

  assign rise = src_req & ~src_req_q;
  assign req  = pending & mask;

  always_comb begin
    ack_clr = '0;
    if (state == ASSERT && irq_ack) ack_clr[irq_id] = 1'b1;
  end

  // Scan starts one past the last granted source so every source gets a turn.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      scan_idx = ID_W'((int'(last_grant) + k) % NUM_SRC);
      if (!found && req[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      src_req_q  <= '0;
      mask       <= MASK_RST;
      last_grant <= ID_W'(NUM_SRC - 1);
      pending    <= '0;
      overflow   <= '0;
      irq        <= 1'b0;
      irq_id     <= '0;
      irq_data   <= '0;
      for (int i = 0; i < NUM_SRC; i++) data_q[i] <= '0;
    end else begin
      src_req_q <= src_req;
      if (mask_we) mask <= mask_wdata;
      pending  <= (pending & ~ack_clr) | rise;
      // A rise coinciding with the ack that clears its pending bit is a fresh request.
      overflow <= (overflow & ~{NUM_SRC{ovf_clr}}) | (rise & pending & ~ack_clr);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (rise[i] && (!pending[i] || ack_clr[i]))
          data_q[i] <= src_data[i*DATA_W +: DATA_W];
      end
      case (state)
        IDLE: begin
          if (found) begin
            irq      <= 1'b1;
            irq_id   <= winner;
            irq_data <= data_q[winner];
            state    <= ASSERT;
          end
        end
        ASSERT: begin
          if (irq_ack) begin
            irq        <= 1'b0;
            last_grant <= irq_id;
            state      <= SERVICE;
          end
        end
        SERVICE: begin
          if (irq_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
